// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: producer and UART-side signals of the transmit FIFO
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              uart_transmit;
  logic [7:0]        uart_tx_byte;
  logic              uart_busy;
  logic              tx_timeout;
  logic              idle;
  modport master (
    output wr_en, wr_data, uart_busy,
    input  full, empty, count, overflow, uart_transmit, uart_tx_byte, tx_timeout, idle
  );
  modport slave (
    input  wr_en, wr_data, uart_busy,
    output full, empty, count, overflow, uart_transmit, uart_tx_byte, tx_timeout, idle
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO plus launch sequencer feeding a UART transmitter
module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int BUSY_TIMEOUT = 15
) (
  input logic           clk,
  input logic           rst,
  uart_tx_fifo_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT_BUSY, S_WAIT_DONE} state_t;
  state_t            state_q, state_d;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [7:0]        tmr_q, tmr_d, byte_q, byte_d;
  logic              xmit_q, xmit_d, ovf_q, ovf_d, tout_q, tout_d;
  logic              push, pop;
  assign bus.full          = count_q == (ADDR_W+1)'(DEPTH);
  assign bus.empty         = count_q == '0;
  assign bus.count         = count_q;
  assign bus.overflow      = ovf_q;
  assign bus.uart_transmit = xmit_q;
  assign bus.uart_tx_byte  = byte_q;
  assign bus.tx_timeout    = tout_q;
  assign bus.idle          = bus.empty && state_q == S_IDLE && !bus.uart_busy;
  // full is judged before the edge, so a same-edge pop never makes room for a write
  assign push = bus.wr_en && !bus.full;
  assign pop  = state_q == S_IDLE && !bus.empty && !bus.uart_busy;
  // storage has no reset; only entries between the pointers are ever read
  always_ff @(posedge clk)
    if (push) mem[wr_ptr_q] <= bus.wr_data;
  // next state: pointers, occupancy and the launch / wait-busy / wait-done sequencer
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    byte_d   = byte_q;
    xmit_d   = 1'b0;
    tout_d   = 1'b0;
    ovf_d    = bus.wr_en && bus.full;
    wr_ptr_d = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    count_d  = count_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
    case (state_q)
      S_IDLE:
        if (pop) begin
          xmit_d  = 1'b1;
          byte_d  = mem[rd_ptr_q];
          tmr_d   = 8'(BUSY_TIMEOUT);
          state_d = S_WAIT_BUSY;
        end
      S_WAIT_BUSY:
        if (bus.uart_busy) state_d = S_WAIT_DONE;
        else if (tmr_q == 8'd0) begin
          tout_d  = 1'b1;
          state_d = S_IDLE;
        end else tmr_d = tmr_q - 8'd1;
      S_WAIT_DONE:
        state_d = bus.uart_busy ? S_WAIT_DONE : S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end
  // state register; reset abandons any byte in flight and empties the queue
  always_ff @(posedge clk)
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tmr_q    <= '0;
      byte_q   <= 8'h00;
      xmit_q   <= 1'b0;
      ovf_q    <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tmr_q    <= tmr_d;
      byte_q   <= byte_d;
      xmit_q   <= xmit_d;
      ovf_q    <= ovf_d;
      tout_q   <= tout_d;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: vector table plus directed sequences for the UART transmit FIFO
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic man_busy = 1'b0;
  logic model_en = 1'b0;
  int   hold = 40;
  int   mcnt = 0;
  logic model_busy;
  logic prev_busy = 1'b0;
  logic prev_xmit = 1'b0;
  int   consec = 0;
  int   busy_viol = 0;
  int   ovf_seen = 0;
  int   total = 0;
  int   passed = 0;
  logic [7:0] rx[$];

  uart_tx_fifo_if #(.ADDR_W(4)) bus ();
  uart_tx_fifo #(.DEPTH(16), .ADDR_W(4), .BUSY_TIMEOUT(15)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  assign model_busy    = mcnt != 0;
  assign bus.uart_busy = model_en ? model_busy : man_busy;

  always @(posedge clk)
    if (rst) mcnt <= 0;
    else if (model_en && bus.uart_transmit) mcnt <= hold;
    else if (mcnt != 0) mcnt <= mcnt - 1;

  always @(posedge clk)
    if (rst) begin
      prev_busy <= 1'b0;
      prev_xmit <= 1'b0;
    end else begin
      if (bus.uart_transmit) rx.push_back(bus.uart_tx_byte);
      if (bus.uart_transmit && prev_xmit) consec <= consec + 1;
      if (bus.uart_transmit && prev_busy) busy_viol <= busy_viol + 1;
      if (bus.overflow) ovf_seen <= ovf_seen + 1;
      prev_busy <= bus.uart_busy;
      prev_xmit <= bus.uart_transmit;
    end

  typedef struct {
    logic       we;
    logic [7:0] wd;
    logic       busy;
    logic [4:0] cnt;
    logic       xmit;
    logic [7:0] byt;
    logic       idle;
  } vec_t;
  vec_t vecs[20];

  function automatic vec_t v(logic we, logic [7:0] wd, logic busy, logic [4:0] cnt,
                             logic xmit, logic [7:0] byt, logic idle);
    vec_t r;
    r.we = we; r.wd = wd; r.busy = busy; r.cnt = cnt; r.xmit = xmit; r.byt = byt; r.idle = idle;
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(string name, int start, int n);
    int k = 0;
    while (!((rx.size() - start) >= n && bus.idle) && k < 5000) begin
      tick;
      k++;
    end
    check(name, 32'(k < 5000), 1);
  endtask

  task automatic check_order(string name, int start, int n, logic [7:0] first);
    int bad = 0;
    for (int i = 0; i < n; i++)
      if (start + i >= rx.size() || rx[start + i] !== 8'(first + 8'(i))) bad++;
    check(name, bad, 0);
  endtask

  initial begin
    int start, n, maxc, ff, sent, k;
    vecs[0]  = v(1, 8'hA5, 0, 1, 0, 8'h00, 0);
    vecs[1]  = v(0, 8'h00, 0, 0, 1, 8'hA5, 0);
    vecs[2]  = v(0, 8'h00, 1, 0, 0, 8'hA5, 0);
    vecs[3]  = v(1, 8'h3C, 1, 1, 0, 8'hA5, 0);
    vecs[4]  = v(1, 8'h5A, 1, 2, 0, 8'hA5, 0);
    vecs[5]  = v(0, 8'h00, 0, 2, 0, 8'hA5, 0);
    vecs[6]  = v(0, 8'h00, 0, 1, 1, 8'h3C, 0);
    vecs[7]  = v(1, 8'h77, 0, 2, 0, 8'h3C, 0);
    vecs[8]  = v(0, 8'h00, 1, 2, 0, 8'h3C, 0);
    vecs[9]  = v(0, 8'h00, 0, 2, 0, 8'h3C, 0);
    vecs[10] = v(0, 8'h00, 1, 2, 0, 8'h3C, 0);
    vecs[11] = v(1, 8'h11, 0, 2, 1, 8'h5A, 0);
    vecs[12] = v(0, 8'h00, 1, 2, 0, 8'h5A, 0);
    vecs[13] = v(0, 8'h00, 0, 2, 0, 8'h5A, 0);
    vecs[14] = v(0, 8'h00, 0, 1, 1, 8'h77, 0);
    vecs[15] = v(0, 8'h00, 1, 1, 0, 8'h77, 0);
    vecs[16] = v(0, 8'h00, 0, 1, 0, 8'h77, 0);
    vecs[17] = v(0, 8'h00, 0, 0, 1, 8'h11, 0);
    vecs[18] = v(0, 8'h00, 1, 0, 0, 8'h11, 0);
    vecs[19] = v(0, 8'h00, 0, 0, 0, 8'h11, 1);
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    tick;
    tick;
    rst = 1'b0;
    check("reset", {bus.count, bus.empty, bus.full, bus.uart_transmit, bus.uart_tx_byte,
                    bus.overflow, bus.tx_timeout, bus.idle}, {5'd0, 1'b1, 1'b0, 1'b0, 8'h00, 3'b001});
    for (int i = 0; i < 20; i++) begin
      bus.wr_en = vecs[i].we;
      bus.wr_data = vecs[i].wd;
      man_busy = vecs[i].busy;
      tick;
      check($sformatf("vec%0d", i),
            {bus.count, bus.uart_transmit, bus.uart_tx_byte, bus.idle, bus.overflow, bus.tx_timeout},
            {vecs[i].cnt, vecs[i].xmit, vecs[i].byt, vecs[i].idle, 2'b00});
    end
    bus.wr_en = 1'b0;
    hold = 40;
    model_en = 1'b1;
    start = rx.size();
    maxc = 0;
    for (int i = 1; i <= 16; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'(i);
      tick;
      if (int'(bus.count) > maxc) maxc = int'(bus.count);
    end
    bus.wr_en = 1'b0;
    drain("t2_drain", start, 16);
    check("t2_peak", 32'(maxc >= 15 && maxc <= 16), 1);
    check("t2_no_overflow", ovf_seen, 0);
    check_order("t2_order", start, 16, 8'h01);
    model_en = 1'b0;
    man_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'(8'h20 + 8'(i));
      tick;
    end
    check("t3_full", {bus.count, bus.full}, {5'd16, 1'b1});
    bus.wr_data = 8'hFF;
    tick;
    check("t3_overflow", {bus.overflow, bus.count}, {1'b1, 5'd16});
    bus.wr_en = 1'b0;
    tick;
    check("t3_overflow_end", {bus.overflow, bus.count}, {1'b0, 5'd16});
    start = rx.size();
    model_en = 1'b1;
    drain("t3_drain", start, 16);
    repeat (5) tick;
    check("t3_count", rx.size() - start, 16);
    check_order("t3_order", start, 16, 8'h20);
    ff = 0;
    foreach (rx[i]) if (rx[i] === 8'hFF) ff++;
    check("t3_no_ff", ff, 0);
    hold = 0;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hB1;
    tick;
    bus.wr_en = 1'b0;
    tick;
    check("t4_launch", {bus.uart_transmit, bus.uart_tx_byte}, {1'b1, 8'hB1});
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hB2;
    n = 0;
    do begin
      tick;
      bus.wr_en = 1'b0;
      n++;
    end while (!bus.tx_timeout && n < 40);
    check("t4_timeout_delay", n, 16);
    tick;
    check("t4_relaunch", {bus.uart_transmit, bus.uart_tx_byte, bus.tx_timeout}, {1'b1, 8'hB2, 1'b0});
    n = 0;
    do begin
      tick;
      n++;
    end while (!bus.tx_timeout && n < 40);
    check("t4_timeout_delay2", n, 16);
    tick;
    check("t4_idle", {bus.idle, bus.tx_timeout}, {1'b1, 1'b0});
    model_en = 1'b0;
    man_busy = 1'b1;
    hold = 3;
    for (int i = 0; i < 5; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'(8'hC0 + 8'(i));
      tick;
    end
    check("t5_count5", bus.count, 5);
    man_busy = 1'b0;
    bus.wr_data = 8'hC5;
    start = rx.size();
    tick;
    check("t5_push_pop", {bus.count, bus.uart_transmit, bus.uart_tx_byte}, {5'd5, 1'b1, 8'hC0});
    model_en = 1'b1;
    sent = 6;
    k = 0;
    while (sent < 26 && k < 2000) begin
      bus.wr_en = !bus.full;
      bus.wr_data = 8'(8'hC0 + 8'(sent));
      if (!bus.full) sent++;
      tick;
      k++;
    end
    bus.wr_en = 1'b0;
    check("t5_pushed", sent, 26);
    drain("t5_drain", start, 26);
    check_order("t5_order", start, 26, 8'hC0);
    model_en = 1'b0;
    man_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'(8'hE0 + 8'(i));
      tick;
    end
    bus.wr_en = 1'b0;
    man_busy = 1'b1;
    tick;
    check("t6_pre_reset", {bus.count, bus.uart_tx_byte}, {5'd3, 8'hE0});
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("t6_reset", {bus.count, bus.empty, bus.uart_transmit, bus.overflow, bus.tx_timeout},
          {5'd0, 1'b1, 3'b000});
    man_busy = 1'b0;
    #1;
    check("t6_idle", bus.idle, 1);
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hF5;
    tick;
    bus.wr_en = 1'b0;
    tick;
    check("t6_launch", {bus.count, bus.uart_transmit, bus.uart_tx_byte}, {5'd0, 1'b1, 8'hF5});
    man_busy = 1'b1;
    tick;
    man_busy = 1'b0;
    tick;
    check("t6_done", bus.idle, 1);
    check("no_consecutive_transmit", consec, 0);
    check("no_transmit_while_busy", busy_viol, 0);
    check("overflow_total", ovf_seen, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
